// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: turns a 1-bit spike train back into a rate count.
// Spikes are counted over a window of WINDOW clock cycles. The saturated
// total is presented on a valid/ready output port.
// Optional build macro: SPIKE_EDGE_DETECT_EN. When it is defined, only
// rising edges of spike_in count. When it is undefined, every high cycle counts.
//
// Handshake: rate_out/rate_valid follow valid/ready semantics. A transfer
// happens on a rising edge with rate_valid=1 and rate_ready=1. rate_out
// holds steady while rate_valid=1 unless a new window result loads over it.
// If it is overwritten before being consumed, overrun pulses for one cycle.
module spike_rate_decoder #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             spike_in,
  input  logic             rate_ready,
  output logic [WIDTH-1:0] rate_out,
  output logic             rate_valid,
  output logic             overrun,
  output logic             o_dbg_state
);

  localparam int               CW   = $clog2(WINDOW);
  localparam logic [CW-1:0]    LAST = CW'(WINDOW - 1);
  localparam logic [WIDTH-1:0] MAXV = '1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_win;
  logic [WIDTH-1:0] r_acc;
  logic             w_qual;
  logic             w_last;
  logic             w_load;
  logic [WIDTH-1:0] w_acc_next;

  // State register; the debug output exposes it directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: COUNT follows enable.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (enable)  w_next_state = S_COUNT;
      S_COUNT: if (!enable) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign o_dbg_state = (r_state == S_COUNT);

`ifdef SPIKE_EDGE_DETECT_EN
  logic r_prev;
  logic w_entering;

  // The cycle that enters COUNT treats the history as 0, so a spike that
  // is already high there counts as a fresh edge.
  assign w_entering = (r_state == S_IDLE) && enable;

  // Spike history for rising-edge detection. It is cleared whenever
  // counting is off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_prev <= 1'b0;
    else if (!enable) r_prev <= 1'b0;
    else              r_prev <= spike_in;
  end

  assign w_qual = enable && spike_in && !(r_prev && !w_entering);
`else
  assign w_qual = enable && spike_in;
`endif

  // Counting starts on the first cycle that enable is high, while the FSM
  // still shows IDLE, so the datapath keys off enable rather than state.
  assign w_last     = (r_win == LAST);
  assign w_load     = enable && w_last;
  assign w_acc_next = (r_acc == MAXV) ? MAXV : r_acc + WIDTH'(w_qual);

  // Window counter and accumulator. Dropping enable aborts the window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win <= '0;
      r_acc <= '0;
    end else if (!enable || w_last) begin
      r_win <= '0;
      r_acc <= '0;
    end else begin
      r_win <= r_win + 1'b1;
      r_acc <= w_acc_next;
    end
  end

  // Output port: a new result wins over a transfer on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_out   <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (w_load) begin
      rate_out   <= w_acc_next;
      rate_valid <= 1'b1;
      overrun    <= rate_valid && !rate_ready;
    end else begin
      overrun <= 1'b0;
      if (rate_valid && rate_ready) rate_valid <= 1'b0;
    end
  end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

- Converts a 1-bit spike train back into a rate count, the receiving end of the counter-based spike generators in the neuron datapath.
- Counts spikes over a fixed window of clock cycles and latches the total.
- Presents the total on a valid/ready output port to downstream neuron or readout logic.

## Interface

Parameters:
- WIDTH, 8, width of the rate count; the count saturates at 2^WIDTH-1.
- WINDOW, 256, window length in clock cycles; legal range is 2 to 65536.

Ports:
- clk  input  1  clock; all logic updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  window counting runs while high.
- spike_in  input  1  incoming spike train, synchronous to clk.
- rate_ready  input  1  downstream accepts rate_out.
- rate_out  output  WIDTH  spike count of the last completed window.
- rate_valid  output  1  rate_out holds an unconsumed result.
- overrun  output  1  one-cycle pulse when an unconsumed result is overwritten.

## Operation

- State machine:
  - IDLE: enable low. Window counter and spike accumulator are held at 0.
  - COUNT: enable high.
  - IDLE to COUNT on enable=1. COUNT to IDLE on enable=0.
- Leaving COUNT mid-window aborts the window:
  - Accumulator and window counter are cleared.
  - No result is produced.
  - rate_out and rate_valid are not affected.
- In COUNT:
  - The window counter runs 0 to WINDOW-1 and then wraps to 0.
  - A qualified spike (see Configuration) increments the accumulator, saturating at 2^WIDTH-1.
- On the window's last cycle (counter = WINDOW-1):
  - result = accumulator + qualified spike of that cycle, saturated.
  - result loads into rate_out and rate_valid is set.
  - The accumulator clears; a spike on the first cycle of the next window counts into the new window.
- Output handshake:
  - A transfer occurs when rate_valid=1 and rate_ready=1 on a rising edge. rate_valid then clears unless a new result loads on the same edge.
  - New result while rate_valid=1 and rate_ready=0: rate_out is overwritten and overrun pulses for 1 cycle.
  - New result on the same edge as a transfer: the new value loads, rate_valid stays 1, and no overrun is raised.
  - rate_out is stable while rate_valid=1 and no new result loads.
- Reset (asynchronous, any time, including mid-window):
  - State goes to IDLE.
  - Window counter and accumulator go to 0.
  - rate_out=0, rate_valid=0, overrun=0.
  - The edge-detect history register goes to 0.

## Timing

- Spikes are sampled on the rising edge of clk.
- First counted cycle: the cycle in which enable is first sampled high (window cycle 0).
- Result latency: rate_out and rate_valid update on the edge that ends window cycle WINDOW-1. They are visible in the following cycle.
- Steady-state throughput: one result every WINDOW cycles, with no dead cycles between windows.
- overrun is high for exactly the one cycle after the overwriting edge.
- rate_ready has no combinational path to any output.

## Configuration

- SPIKE_EDGE_DETECT_EN defined:
  - A qualified spike is a rising edge of spike_in (spike_in=1 and previous sample=0).
  - A spike held high for N cycles counts once.
  - The history register is cleared on reset and on entry to COUNT.
- SPIKE_EDGE_DETECT_EN undefined:
  - Every cycle with spike_in=1 in COUNT is a qualified spike.
  - No history register is built.

## Test plan

- Level count (WIDTH=8, WINDOW=16, macro undefined):
  - Stimulus: enable=1, spike_in=1 constantly, rate_ready=1.
  - Required: rate_out=16 with a rate_valid pulse every 16 cycles, first result 16 cycles after enable, overrun never asserts.
- Edge count (same parameters, macro defined):
  - Stimulus: spike_in toggles every 2 cycles (pattern 1100…).
  - Required: rate_out=4 per window. Then hold spike_in=1 for a full window; required rate_out=0 for that window.
- Saturation (WIDTH=4, WINDOW=32, macro undefined):
  - Stimulus: spike_in=1 constantly.
  - Required: rate_out=15, no wrap to 0.
- Backpressure (WINDOW=16):
  - Stimulus: hold rate_ready=0 across two windows, with 3 spikes in the first window and 7 in the second.
  - Required: rate_out goes 3 then 7, overrun pulses once, rate_valid stays 1. Then raise rate_ready for 1 cycle; required rate_valid=0 on the next cycle.
- Abort and reset:
  - Stimulus: drop enable at window cycle 9 after 5 spikes, then re-enable with 2 spikes in a full window.
  - Required: only rate_out=2 is produced.
  - Stimulus: assert reset low mid-window while rate_valid=1.
  - Required: rate_out=0 and rate_valid=0 immediately, without waiting for a clock edge.
- Simultaneous transfer and new result:
  - Stimulus: rate_ready=1 on the exact edge a window completes while rate_valid=1.
  - Required: the new value is visible, rate_valid=1, overrun=0.
